// File: rtl/sat_mac_if.sv
// Bus bundle for sat_mac_accumulator: beat input channel and frame result channel.
//
// Handshake rules (both channels): a transfer happens on a rising clock edge
// where valid and ready are both 1. The producer keeps valid and its payload
// stable until that transfer; ready never depends combinationally on valid.
interface sat_mac_if #(
  parameter int WIDTH = 16,
  parameter int LANES = 4,
  parameter int CNT_W = 16
);
  logic                     in_valid;
  logic                     in_ready;
  logic [LANES*WIDTH-1:0]   in_data;
  logic                     in_last;
  logic                     out_valid;
  logic                     out_ready;
  logic [WIDTH-1:0]         out_data;
  logic                     out_sat;
  logic [CNT_W-1:0]         out_beats;

  // Producer of beats / consumer of results.
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_sat, out_beats
  );

  // The accumulator itself.
  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_sat, out_beats
  );
endinterface

// File: rtl/sat_mac_accumulator.sv
// Multi-lane saturating (or wrapping) accumulator with framed output.
// Stage 1 registers the exact lane sum, stage 2 folds it into the running
// accumulator with per-step clamping; the last beat loads the output register.
module sat_mac_accumulator #(
  parameter int WIDTH  = 16,
  parameter int LANES  = 4,
  parameter int SAT_EN = 1,
  parameter int CNT_W  = 16
) (
  input  logic       clk,
  input  logic       rst,
  sat_mac_if.slave   bus,
  output logic [1:0] dbg_state
);

  // Tree width is exact for LANES lanes; one extra bit absorbs acc + tree.
  localparam int TW = WIDTH + $clog2(LANES);
  localparam int EW = TW + 1;

  localparam logic signed [EW-1:0]    MAX_EXT = {{(EW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [EW-1:0]    MIN_EXT = {{(EW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
  localparam logic signed [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_ACC   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   in_ready, out_valid, accept;

  logic                    s1_valid_q, s1_valid_d;
  logic                    s1_last_q, s1_last_d;
  logic signed [TW-1:0]    s1_sum_q, s1_sum_d;
  logic signed [TW-1:0]    tree_sum;

  logic signed [WIDTH-1:0] acc_q, acc_d;
  logic                    sat_q, sat_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  logic [WIDTH-1:0]        out_data_q, out_data_d;
  logic                    out_sat_q, out_sat_d;
  logic [CNT_W-1:0]        out_beats_q, out_beats_d;

  logic signed [EW-1:0]    acc_ext;
  logic                    ovf;
  logic signed [WIDTH-1:0] acc_step;

  assign accept = bus.in_valid & in_ready;

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_ACC;
    else     state_q <= state_d;
  end

  // FSM next state: a frame closes on the accepted last beat, drains one
  // cycle through stage 2, then waits for the result to be taken.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ACC:   if (accept && bus.in_last)      state_d = ST_DRAIN;
      ST_DRAIN: if (s1_valid_q && s1_last_q)    state_d = ST_HOLD;
      ST_HOLD:  if (bus.out_ready)              state_d = ST_ACC;
      default:                                  state_d = ST_ACC;
    endcase
  end

  // FSM outputs: decoded from the state register only, never from out_ready.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ST_ACC:  in_ready  = 1'b1;
      ST_HOLD: out_valid = 1'b1;
      default: ;
    endcase
  end

  // Exact signed lane sum; sign-extension of every lane keeps it overflow-free.
  always_comb begin
    tree_sum = '0;
    for (int k = 0; k < LANES; k++) begin
      tree_sum = tree_sum + TW'($signed(bus.in_data[k*WIDTH +: WIDTH]));
    end
  end

  // Stage 1 next values: capture the tree sum only on an accepted beat.
  always_comb begin
    s1_valid_d = accept;
    s1_last_d  = accept & bus.in_last;
    s1_sum_d   = accept ? tree_sum : s1_sum_q;
  end

  // Stage 2 step: widened add, overflow detect, clamp or wrap.
  always_comb begin
    acc_ext  = EW'(acc_q) + EW'(s1_sum_q);
    ovf      = (acc_ext > MAX_EXT) || (acc_ext < MIN_EXT);
    acc_step = acc_ext[WIDTH-1:0];
    if (ovf && (SAT_EN != 0)) acc_step = acc_ext[EW-1] ? SAT_MIN : SAT_MAX;
  end

  // Accumulator, sticky flag, beat counter and output register next values.
  always_comb begin
    acc_d       = acc_q;
    sat_d       = sat_q;
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;
    out_beats_d = out_beats_q;
    if (accept && !(&cnt_q)) cnt_d = cnt_q + CNT_W'(1);
    if (s1_valid_q) begin
      if (s1_last_q) begin
        // Result moves out; the next frame starts from a clean slate.
        out_data_d  = acc_step;
        out_sat_d   = sat_q | ovf;
        out_beats_d = cnt_q;
        acc_d       = '0;
        sat_d       = 1'b0;
        cnt_d       = '0;
      end else begin
        acc_d = acc_step;
        sat_d = sat_q | ovf;
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_sum_q    <= '0;
      acc_q       <= '0;
      sat_q       <= 1'b0;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
      out_beats_q <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_last_q   <= s1_last_d;
      s1_sum_q    <= s1_sum_d;
      acc_q       <= acc_d;
      sat_q       <= sat_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
      out_beats_q <= out_beats_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_data_q;
  assign bus.out_sat   = out_sat_q;
  assign bus.out_beats = out_beats_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_sat_mac_accumulator.sv
// Bench for sat_mac_accumulator: a clamping instance (CNT_W=16) and a wrapping
// instance (CNT_W=3) see identical stimulus and are compared against an
// integer-arithmetic model of the frame result.
module tb_sat_mac_accumulator;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sat_mac_if #(.WIDTH(16), .LANES(4), .CNT_W(16)) bus0 ();
  sat_mac_if #(.WIDTH(16), .LANES(4), .CNT_W(3))  bus1 ();
  logic [1:0] dbg0, dbg1;

  logic rand_ready, rr_bit, fixed_ready;
  assign bus0.out_ready = rand_ready ? rr_bit : fixed_ready;
  assign bus1.out_ready = bus0.out_ready;
  assign bus1.in_valid  = bus0.in_valid;
  assign bus1.in_data   = bus0.in_data;
  assign bus1.in_last   = bus0.in_last;

  sat_mac_accumulator #(.WIDTH(16), .LANES(4), .SAT_EN(1), .CNT_W(16)) u_dut_sat (
    .clk(clk), .rst(rst), .bus(bus0.slave), .dbg_state(dbg0));
  sat_mac_accumulator #(.WIDTH(16), .LANES(4), .SAT_EN(0), .CNT_W(3)) u_dut_wrap (
    .clk(clk), .rst(rst), .bus(bus1.slave), .dbg_state(dbg1));

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Index 0: clamping instance, index 1: wrapping instance.
  int m_acc [2];
  bit m_sat [2];
  int m_n;
  logic [32:0] exp0_q[$];  // {sat, beats[15:0], data[15:0]}
  logic [19:0] exp1_q[$];  // {sat, beats[2:0], data[15:0]}

  function automatic void model_reset();
    m_acc[0] = 0; m_acc[1] = 0;
    m_sat[0] = 0; m_sat[1] = 0;
    m_n = 0;
  endfunction

  function automatic void model_beat(input logic [63:0] d, input bit last);
    int tree, ext;
    logic signed [15:0] lane;
    logic [15:0] t0, t1, b0;
    logic [2:0] b1;
    tree = 0;
    for (int k = 0; k < 4; k++) begin
      lane = d[k*16 +: 16];
      tree += int'(lane);
    end
    m_n++;
    for (int m = 0; m < 2; m++) begin
      ext = m_acc[m] + tree;
      if (ext > 32767 || ext < -32768) begin
        m_sat[m] = 1;
        if (m == 0) ext = (ext > 0) ? 32767 : -32768;
        else begin
          lane = ext[15:0];
          ext  = int'(lane);
        end
      end
      m_acc[m] = ext;
    end
    if (last) begin
      t0 = m_acc[0][15:0];
      t1 = m_acc[1][15:0];
      b0 = (m_n > 65535) ? 16'hFFFF : m_n[15:0];
      b1 = (m_n > 7) ? 3'd7 : m_n[2:0];
      exp0_q.push_back({m_sat[0], b0, t0});
      exp1_q.push_back({m_sat[1], b1, t1});
      model_reset();
    end
  endfunction

  // ---------------- scoreboard monitor ----------------
  logic [32:0] e0;
  logic [19:0] e1;
  always @(negedge clk) begin
    if (!rst && bus0.out_valid && bus0.out_ready) begin
      if (exp0_q.size() == 0) begin
        check("spurious_out", bus0.out_valid, 1'b0);
      end else begin
        e0 = exp0_q.pop_front();
        e1 = exp1_q.pop_front();
        check("sat_data",   bus0.out_data,  e0[15:0]);
        check("sat_beats",  bus0.out_beats, e0[31:16]);
        check("sat_flag",   bus0.out_sat,   e0[32]);
        check("wrap_valid", bus1.out_valid, 1'b1);
        check("wrap_data",  bus1.out_data,  e1[15:0]);
        check("wrap_beats", bus1.out_beats, e1[18:16]);
        check("wrap_flag",  bus1.out_sat,   e1[19]);
      end
    end
  end

  // Random consumer readiness, changed just after the active edge.
  always @(posedge clk) begin
    #1 rr_bit = ($urandom_range(0, 3) != 0);
  end

  // ---------------- driver tasks ----------------
  task automatic idle_garbage();
    bus0.in_valid = 1'b0;
    bus0.in_data  = {$urandom, $urandom};
    bus0.in_last  = 1'($urandom_range(0, 1));
  endtask

  task automatic send_beat(input logic [63:0] d, input bit last);
    int w;
    @(negedge clk);
    bus0.in_valid = 1'b1;
    bus0.in_data  = d;
    bus0.in_last  = last;
    w = 0;
    while (!bus0.in_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!bus0.in_ready) begin
      check("accept_timeout", bus0.in_ready, 1'b1);
    end else begin
      @(posedge clk);
      model_beat(d, last);
    end
    #1 idle_garbage();
  endtask

  task automatic wait_drain();
    int w;
    w = 0;
    while ((exp0_q.size() != 0) && w < 500) begin
      @(negedge clk);
      w++;
    end
    check("drain_pending", exp0_q.size(), 0);
    @(negedge clk);
  endtask

  function automatic logic [15:0] rand_lane();
    case ($urandom_range(0, 3))
      0:       return ($urandom_range(0, 1) != 0) ? 16'h7FFF : 16'h8000;
      1:       return 16'($urandom_range(0, 40)) - 16'd20;
      default: return 16'($urandom);
    endcase
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    int nb;
    logic [63:0] d;
    rst = 1'b1;
    rand_ready = 1'b0;
    fixed_ready = 1'b0;
    idle_garbage();
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_in_ready",  bus0.in_ready,  1'b1);
    check("rst_out_valid", bus0.out_valid, 1'b0);
    check("rst_out_data",  bus0.out_data,  16'd0);
    check("rst_out_sat",   bus0.out_sat,   1'b0);
    check("rst_out_beats", bus0.out_beats, 16'd0);
    rst = 1'b0;

    // Single beat latency: accept at T, out_valid at T+2, in_ready back after handshake.
    fixed_ready = 1'b1;
    send_beat({16'hFFFC, 16'd3, 16'd2, 16'd1}, 1'b1);
    @(negedge clk);
    check("lat_t1_in_ready",  bus0.in_ready,  1'b0);
    check("lat_t1_out_valid", bus0.out_valid, 1'b0);
    @(negedge clk);
    check("lat_t2_out_valid", bus0.out_valid, 1'b1);
    check("lat_t2_in_ready",  bus0.in_ready,  1'b0);
    check("lat_t2_data",      bus0.out_data,  16'd2);
    check("lat_t2_beats",     bus0.out_beats, 16'd1);
    @(negedge clk);
    check("lat_t3_out_valid", bus0.out_valid, 1'b0);
    check("lat_t3_in_ready",  bus0.in_ready,  1'b1);

    // Positive clamp over three beats.
    send_beat({16'h0, 16'h0, 16'h4000, 16'h4000}, 1'b0);
    send_beat({16'h0, 16'h0, 16'h4000, 16'h4000}, 1'b0);
    send_beat({16'h0, 16'h0, 16'h4000, 16'h4000}, 1'b1);
    wait_drain();
    // Negative clamp in a single beat.
    send_beat({16'h8000, 16'h8000, 16'h8000, 16'h8000}, 1'b1);
    wait_drain();
    // Clamp then recover (wrap instance wraps to 0x8000 then 0x7FFF).
    send_beat({16'h0, 16'h0, 16'h0001, 16'h7FFF}, 1'b0);
    send_beat({16'h0, 16'h0, 16'h0000, 16'hFFFF}, 1'b1);
    wait_drain();

    // Backpressure: result held stable, offered beats ignored.
    @(posedge clk);
    #1 fixed_ready = 1'b0;
    send_beat({16'h0, 16'h0, 16'h0, 16'd300}, 1'b0);
    send_beat({16'h0, 16'h0, 16'd9, 16'd300}, 1'b1);
    nb = 0;
    while (!bus0.out_valid && nb < 20) begin
      @(negedge clk);
      nb++;
    end
    check("bp_out_valid", bus0.out_valid, 1'b1);
    for (int i = 0; i < 5; i++) begin
      bus0.in_valid = 1'b1;
      bus0.in_data  = {$urandom, $urandom};
      bus0.in_last  = 1'b1;
      check("bp_hold_valid", bus0.out_valid, 1'b1);
      check("bp_in_ready",   bus0.in_ready,  1'b0);
      check("bp_hold_data",  bus0.out_data,  exp0_q[0][15:0]);
      check("bp_hold_sat",   bus0.out_sat,   exp0_q[0][32]);
      check("bp_hold_beats", bus0.out_beats, exp0_q[0][31:16]);
      @(negedge clk);
    end
    idle_garbage();
    @(posedge clk);
    #1 fixed_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_rel_in_ready",  bus0.in_ready,  1'b1);
    check("bp_rel_out_valid", bus0.out_valid, 1'b0);
    send_beat({16'h0, 16'h0, 16'h0, 16'd5}, 1'b1);
    wait_drain();

    // Reset in the middle of a frame discards it.
    send_beat({16'h0, 16'h0, 16'h0, 16'd100}, 1'b0);
    send_beat({16'h0, 16'h0, 16'h0, 16'd100}, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    #1;
    check("rst_mid_out_valid", bus0.out_valid, 1'b0);
    check("rst_mid_in_ready",  bus0.in_ready,  1'b1);
    @(negedge clk);
    rst = 1'b0;
    send_beat({16'h0, 16'h0, 16'h0, 16'd7}, 1'b1);
    wait_drain();

    // Randomized frames with idle gaps and random consumer readiness.
    rand_ready = 1'b1;
    for (int f = 0; f < 40; f++) begin
      nb = $urandom_range(1, 10);
      for (int b = 0; b < nb; b++) begin
        if ($urandom_range(0, 3) == 0) begin
          repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        d = {rand_lane(), rand_lane(), rand_lane(), rand_lane()};
        send_beat(d, b == nb - 1);
      end
    end
    @(posedge clk);
    #2 rand_ready = 1'b0;
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time bound.
  initial begin
    #1000000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sat_mac_accumulator.md
# sat_mac_accumulator

Parametrised multi-lane saturating fixed-point accumulator for the neuron datapath. Each accepted beat sums LANES signed WIDTH-bit inputs in an exact adder tree, then adds the tree sum into a running accumulator with per-step clamping, not wrap-around. A frame ends with `in_last`. The result is held in an output register under valid/ready backpressure, with a sticky saturation flag and a beat count. It succeeds the single-cycle 16-bit saturating adder: it clamps correctly in both directions, has a selectable wrap mode, and is pipelined and framed.

## Interface
Parameters:
- WIDTH, 16: signed two's-complement data width, Q-format agnostic.
- LANES, 4: inputs summed per beat. Must be ≥1; power of two not required.
- SAT_EN, 1: 1 clamps to the WIDTH range; 0 wraps (truncates to WIDTH).
- CNT_W, 16: width of the beat counter.

Ports (clock is `clk`; one clock; reset `rst` is asynchronous and active-high):
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  beat present
- in_ready  out  1  block accepts a beat this cycle
- in_data  in  LANES*WIDTH  lane k at bits [k*WIDTH +: WIDTH], signed
- in_last  in  1  final beat of the frame, qualified by in_valid
- out_valid  out  1  result held
- out_ready  in  1  consumer takes the result
- out_data  out  WIDTH  signed frame result
- out_sat  out  1  overflow occurred at any step of this frame
- out_beats  out  CNT_W  beats accepted in the frame; saturates at all-ones

## Operation
- Accept: a beat is accepted when `in_valid & in_ready`.
- FSM states:
  - ACC: in_ready=1. Accepting a beat with in_last moves to DRAIN.
  - DRAIN: in_ready=0. Stage 2 absorbs the last beat, then moves to HOLD.
  - HOLD: out_valid=1, in_ready=0. On `out_ready` moves to ACC.
- Stage 1 (registered): tree_sum = exact signed sum of the LANES lanes, width WIDTH+clog2(LANES), never overflows. A valid bit and a last bit travel with it.
- Stage 2 (registered): acc_ext = sign-extended acc + sign-extended tree_sum, computed at WIDTH+clog2(LANES)+1 bits.
  - If acc_ext > 2^(WIDTH-1)-1 or acc_ext < -2^(WIDTH-1), the step overflows.
  - SAT_EN=1: acc takes the clamped value.
  - SAT_EN=0: acc takes the low WIDTH bits of acc_ext.
  - Either mode: the sat flag is set on overflow.
  - Clamping happens per step; later beats accumulate from the clamped value.
- Frame start: acc, the sat flag and the beat counter are zero at the start of every frame. They are cleared when the result moves into the output register.
- Beat counter: increments on each accepted beat and sticks at 2^CNT_W-1.
- Output register: when the last beat leaves stage 2, the final acc, sat and count load into out_data, out_sat and out_beats. These are stable throughout HOLD.
- Reset values: all outputs 0 except in_ready=1. State is ACC; acc, flags, counter and pipeline valids are 0.
- Reset mid-frame: the partial frame is discarded, nothing is emitted, and the next accepted beat starts a new frame.
- in_valid low mid-frame: no effect; the frame stays open indefinitely.
- Beats with in_valid=0: must not disturb the accumulator, regardless of in_data or in_last.

## Timing
- Latency: last beat accepted in cycle T gives out_valid=1 in cycle T+2.
- Frame occupancy: minimum N+2 cycles for an N-beat frame, plus 1 cycle for the HOLD handshake.
- Throughput: one beat per cycle inside a frame.
- in_ready is 0 in cycles T+1 through the handshake cycle. It is 1 in the cycle after out_valid&out_ready.
- out_valid drops in the cycle after the handshake.
- in_ready is a registered function of state only; it has no combinational path from out_ready.

## Test plan
WIDTH=16, LANES=4, SAT_EN=1 unless stated.
- Single beat {1,2,3,-4} with last, out_ready=1 → out_data=2 two cycles after accept, out_sat=0, out_beats=1, in_ready back to 1 next cycle.
- Positive clamp: 3 beats {0x4000,0x4000,0,0}, last on beat 3 → out_data=0x7FFF, out_sat=1, out_beats=3.
- Negative clamp: 1 beat {0x8000,0x8000,0x8000,0x8000} → tree=-131072, out_data=0x8000, out_sat=1.
- Clamp then recover: beat1 {0x7FFF,1,0,0}, beat2 {0xFFFF,0,0,0} with last → out_data=0x7FFE, out_sat=1 (sticky). The same stimulus with SAT_EN=0 → beat1 wraps to 0x8000, out_data=0x7FFF, out_sat=1.
- Backpressure: out_ready=0 for 5 cycles after out_valid → out_data/out_sat/out_beats stable, in_ready=0, in_valid beats ignored. Release → in_ready=1 one cycle after the handshake; the next frame {5,0,0,0} gives 5 with out_sat=0.
- Reset mid-frame: 2 beats of {100,0,0,0}, assert rst for 1 cycle, then 1 beat {7,0,0,0} with last → out_data=7, out_beats=1. During rst: out_valid=0, in_ready=1.
